// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if
// Groups the pipeline-side request signals, the byte-wide RAM port and the
// load result of mem_access_ctrl into one bundle.
//
// Signals:
//   MEM_enable_instr, MEM_RW, MEM_size, MEM_ALU_out, MEM_PD
//       Request from the EX_MEM register: enable, 1=store/0=load,
//       1=word/0=byte, byte address, store data.
//   Mem_RData           byte read from RAM (combinational on Mem_Addr)
//   Mem_Addr, Mem_WData, Mem_WE
//       Byte address, write data and write strobe towards RAM.
//   MEM_stall           pipeline freeze while an access is in progress
//   Load_data, Load_valid
//       Assembled load result and its one-cycle valid pulse.
//   Align_err           misaligned word access flag
//
// Modports:
//   master  the pipeline plus RAM side that drives requests and read data
//   slave   the access controller itself
interface mem_access_ctrl_if;
    logic        MEM_enable_instr;
    logic        MEM_RW;
    logic        MEM_size;
    logic [7:0]  MEM_ALU_out;
    logic [31:0] MEM_PD;
    logic [7:0]  Mem_RData;
    logic [7:0]  Mem_Addr;
    logic [7:0]  Mem_WData;
    logic        Mem_WE;
    logic        MEM_stall;
    logic [31:0] Load_data;
    logic        Load_valid;
    logic        Align_err;

    modport master (
        output MEM_enable_instr, MEM_RW, MEM_size, MEM_ALU_out, MEM_PD, Mem_RData,
        input  Mem_Addr, Mem_WData, Mem_WE, MEM_stall, Load_data, Load_valid, Align_err
    );

    modport slave (
        input  MEM_enable_instr, MEM_RW, MEM_size, MEM_ALU_out, MEM_PD, Mem_RData,
        output Mem_Addr, Mem_WData, Mem_WE, MEM_stall, Load_data, Load_valid, Align_err
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// Turns a byte or big-endian word load/store from the MEM pipeline stage into
// a sequence of single-byte RAM accesses, stalling the pipeline until done.
// Word accesses take IDLE + 4 XFER cycles, byte accesses IDLE + 1 XFER cycle,
// followed by one stall-free DONE cycle in which a load result is presented.
//
// Ports:
//   Clk    clock, rising edge
//   Reset  asynchronous, active-low reset
//   bus    mem_access_ctrl_if.slave (request, RAM port, load result, flags)
//
// Configuration:
//   MEM_ACCESS_ALIGN_CHECK_EN  when defined, a word access with a non-zero
//   low address pair skips the RAM entirely and reports Align_err in DONE
//   (a load also returns zero). When undefined, word addresses are simply
//   aligned down and Align_err is held at 0.
module mem_access_ctrl (
    input  logic             Clk,
    input  logic             Reset,
    mem_access_ctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t      state_q;
    logic [1:0]  cnt_q;
    logic [23:0] asmWord_q;
    logic [31:0] loadData_q;
    logic        loadValid_q;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    logic        alignErr_q;
`endif

    logic        lastByte;
    logic        misaligned;
    logic [7:0]  storeByte;

    // A byte access finishes after its first XFER cycle, a word after cnt=3.
    assign lastByte = !bus.MEM_size || (cnt_q == 2'd3);

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    assign misaligned = bus.MEM_size && (bus.MEM_ALU_out[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // Big-endian lane select: cnt=0 carries the most significant byte.
    always_comb begin
        storeByte = bus.MEM_PD[7:0];
        if (bus.MEM_size) begin
            case (cnt_q)
                2'd0:    storeByte = bus.MEM_PD[31:24];
                2'd1:    storeByte = bus.MEM_PD[23:16];
                2'd2:    storeByte = bus.MEM_PD[15:8];
                default: storeByte = bus.MEM_PD[7:0];
            endcase
        end
    end

    // The RAM port is driven straight from the held request inputs during
    // XFER so nothing is latched; the address wraps because the upper bits
    // come from MEM_ALU_out and only the low pair is replaced by cnt.
    always_comb begin
        bus.Mem_Addr  = 8'h00;
        bus.Mem_WData = 8'h00;
        bus.Mem_WE    = 1'b0;
        if (state_q == XFER) begin
            bus.Mem_Addr = bus.MEM_size ? {bus.MEM_ALU_out[7:2], cnt_q} : bus.MEM_ALU_out;
            if (bus.MEM_RW) begin
                bus.Mem_WE    = 1'b1;
                bus.Mem_WData = storeByte;
            end
        end
    end

    // Reset is folded in so the stall drops the instant Reset goes low.
    assign bus.MEM_stall  = Reset && bus.MEM_enable_instr && (state_q != DONE);
    assign bus.Load_data  = loadData_q;
    assign bus.Load_valid = loadValid_q;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    assign bus.Align_err  = alignErr_q;
`else
    assign bus.Align_err  = 1'b0;
`endif

    // Access sequencer. Load bytes are shifted into asmWord_q; on the last
    // byte the result register is written so it is visible throughout DONE,
    // where Load_valid pulses for exactly that one cycle.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= IDLE;
            cnt_q       <= 2'd0;
            asmWord_q   <= 24'h0;
            loadData_q  <= 32'h0;
            loadValid_q <= 1'b0;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
            alignErr_q  <= 1'b0;
`endif
        end else begin
            loadValid_q <= 1'b0;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
            alignErr_q  <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (bus.MEM_enable_instr) begin
                        cnt_q <= 2'd0;
                        if (misaligned) begin
                            state_q <= DONE;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
                            alignErr_q <= 1'b1;
`endif
                            if (!bus.MEM_RW) begin
                                loadData_q  <= 32'h0;
                                loadValid_q <= 1'b1;
                            end
                        end else begin
                            state_q <= XFER;
                        end
                    end
                end
                XFER: begin
                    if (!bus.MEM_RW) begin
                        asmWord_q <= {asmWord_q[15:0], bus.Mem_RData};
                    end
                    if (lastByte) begin
                        state_q <= DONE;
                        if (!bus.MEM_RW) begin
                            loadValid_q <= 1'b1;
                            loadData_q  <= bus.MEM_size ? {asmWord_q, bus.Mem_RData}
                                                        : {24'h0, bus.Mem_RData};
                        end
                    end else begin
                        cnt_q <= cnt_q + 2'd1;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl
// Directed bench for mem_access_ctrl: a byte-wide RAM model answers the
// controller, and each access records stall length, write strobes, load
// pulses and the DONE-cycle result for comparison with hand-computed values.
module tb_mem_access_ctrl;

    logic Clk;
    logic Reset;
    mem_access_ctrl_if bus();

    mem_access_ctrl dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    // 100 MHz-style free-running clock.
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Byte RAM: combinational read, write on rising edge; pokes preload it.
    logic [7:0] ram [0:255];
    logic       pokeEn;
    logic [7:0] pokeAddr;
    logic [7:0] pokeData;

    assign bus.Mem_RData = ram[bus.Mem_Addr];

    always @(posedge Clk) begin
        if (bus.Mem_WE) ram[bus.Mem_Addr] <= bus.Mem_WData;
        if (pokeEn) ram[pokeAddr] <= pokeData;
    end

    int cycleCount;
    always @(posedge Clk) cycleCount <= cycleCount + 1;

    int compared;
    int mismatched;

    int          gapCycles;
    int          stallCycles;
    int          weCycles;
    int          validCount;
    int          doneCycle;
    logic [31:0] doneData;
    logic        doneValid;
    logic        doneAlign;

    // Single comparison point: counts and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Preload one RAM byte through the model's write port.
    task automatic pokeRam(input logic [7:0] addr, input logic [7:0] data);
        pokeAddr = addr;
        pokeData = data;
        pokeEn   = 1'b1;
        @(posedge Clk);
        #1 pokeEn = 1'b0;
    endtask

    // Present one request (caller sits at a negedge, possibly in DONE) and
    // follow it to its DONE cycle, recording what was observed on the way.
    task automatic applyStimulus(input logic rw, input logic size,
                                 input logic [7:0] addr, input logic [31:0] pd);
        bus.MEM_enable_instr = 1'b1;
        bus.MEM_RW           = rw;
        bus.MEM_size         = size;
        bus.MEM_ALU_out      = addr;
        bus.MEM_PD           = pd;
        gapCycles   = 0;
        stallCycles = 0;
        weCycles    = 0;
        validCount  = 0;
        #1;
        while (!bus.MEM_stall && gapCycles < 20) begin
            @(negedge Clk);
            #1 gapCycles++;
        end
        while (bus.MEM_stall && stallCycles < 20) begin
            stallCycles++;
            if (bus.Mem_WE) weCycles++;
            if (bus.Load_valid) validCount++;
            @(negedge Clk);
            #1;
        end
        doneCycle = cycleCount;
        doneData  = bus.Load_data;
        doneValid = bus.Load_valid;
        doneAlign = bus.Align_err;
        if (bus.Load_valid) validCount++;
        if (bus.Mem_WE) weCycles++;
    endtask

    task automatic idleCycle();
        bus.MEM_enable_instr = 1'b0;
        @(negedge Clk);
        #1;
    endtask

    int firstDone;

    initial begin
        compared         = 0;
        mismatched       = 0;
        cycleCount       = 0;
        pokeEn           = 1'b0;
        pokeAddr         = 8'h00;
        pokeData         = 8'h00;
        Reset            = 1'b0;
        bus.MEM_enable_instr = 1'b1;
        bus.MEM_RW       = 1'b1;
        bus.MEM_size     = 1'b1;
        bus.MEM_ALU_out  = 8'h44;
        bus.MEM_PD       = 32'hFFFF_FFFF;

        // Reset state, with a request already asserted to prove the stall is held low.
        #2;
        checkOutput("rst_stall", {31'h0, bus.MEM_stall}, 32'h0);
        checkOutput("rst_we", {31'h0, bus.Mem_WE}, 32'h0);
        checkOutput("rst_addr", {24'h0, bus.Mem_Addr}, 32'h0);
        checkOutput("rst_wdata", {24'h0, bus.Mem_WData}, 32'h0);
        checkOutput("rst_ldata", bus.Load_data, 32'h0);
        checkOutput("rst_lvalid", {31'h0, bus.Load_valid}, 32'h0);
        checkOutput("rst_align", {31'h0, bus.Align_err}, 32'h0);
        bus.MEM_enable_instr = 1'b0;

        pokeRam(8'h10, 8'hAA);
        pokeRam(8'h11, 8'hBB);
        pokeRam(8'h12, 8'hCC);
        pokeRam(8'h13, 8'hDD);
        pokeRam(8'h05, 8'hF0);
        pokeRam(8'h20, 8'h00);
        pokeRam(8'h21, 8'h00);
        pokeRam(8'h22, 8'h00);
        pokeRam(8'h23, 8'h00);
        @(negedge Clk);
        Reset = 1'b1;
        idleCycle();

        // Word load from 0x10.
        applyStimulus(1'b0, 1'b1, 8'h10, 32'h0);
        checkOutput("wl_gap", gapCycles, 0);
        checkOutput("wl_stall", stallCycles, 5);
        checkOutput("wl_we", weCycles, 0);
        checkOutput("wl_valid_cnt", validCount, 1);
        checkOutput("wl_done_valid", {31'h0, doneValid}, 32'h1);
        checkOutput("wl_data", doneData, 32'hAABB_CCDD);
        checkOutput("wl_align", {31'h0, doneAlign}, 32'h0);
        idleCycle();
        checkOutput("wl_valid_after", {31'h0, bus.Load_valid}, 32'h0);
        checkOutput("wl_data_hold", bus.Load_data, 32'hAABB_CCDD);

        // Word store to 0x20.
        applyStimulus(1'b1, 1'b1, 8'h20, 32'h1122_3344);
        checkOutput("ws_stall", stallCycles, 5);
        checkOutput("ws_we", weCycles, 4);
        checkOutput("ws_valid_cnt", validCount, 0);
        checkOutput("ws_data_hold", doneData, 32'hAABB_CCDD);
        idleCycle();
        checkOutput("ws_ram20", {24'h0, ram[8'h20]}, 32'h11);
        checkOutput("ws_ram21", {24'h0, ram[8'h21]}, 32'h22);
        checkOutput("ws_ram22", {24'h0, ram[8'h22]}, 32'h33);
        checkOutput("ws_ram23", {24'h0, ram[8'h23]}, 32'h44);

        // Byte load then byte store at 0x05 (only PD[7:0] may reach RAM).
        applyStimulus(1'b0, 1'b0, 8'h05, 32'h0);
        checkOutput("bl_stall", stallCycles, 2);
        checkOutput("bl_done_valid", {31'h0, doneValid}, 32'h1);
        checkOutput("bl_data", doneData, 32'h0000_00F0);
        idleCycle();
        applyStimulus(1'b1, 1'b0, 8'h05, 32'hA5C3_E75A);
        checkOutput("bs_stall", stallCycles, 2);
        checkOutput("bs_we", weCycles, 1);
        checkOutput("bs_valid_cnt", validCount, 0);
        idleCycle();
        checkOutput("bs_ram05", {24'h0, ram[8'h05]}, 32'h5A);
        checkOutput("bs_data_hold", bus.Load_data, 32'h0000_00F0);

        // Back-to-back store then load at 0x30: DONE, one IDLE, 4 XFER, DONE.
        applyStimulus(1'b1, 1'b1, 8'h30, 32'hDEAD_BEEF);
        firstDone = doneCycle;
        applyStimulus(1'b0, 1'b1, 8'h30, 32'h0);
        checkOutput("b2b_gap", gapCycles, 1);
        checkOutput("b2b_stall", stallCycles, 5);
        checkOutput("b2b_spacing", doneCycle - firstDone, 6);
        checkOutput("b2b_data", doneData, 32'hDEAD_BEEF);
        idleCycle();

        // Top-of-memory word store: addresses stay within 0xFC..0xFF.
        applyStimulus(1'b1, 1'b1, 8'hFF, 32'h0102_0304);
        idleCycle();
        checkOutput("wrap_ramFC", {24'h0, ram[8'hFC]}, 32'h01);
        checkOutput("wrap_ramFF", {24'h0, ram[8'hFF]}, 32'h04);

        // Misaligned word load at 0x13.
        applyStimulus(1'b0, 1'b1, 8'h13, 32'h0);
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
        checkOutput("mis_stall", stallCycles, 1);
        checkOutput("mis_align", {31'h0, doneAlign}, 32'h1);
        checkOutput("mis_valid", {31'h0, doneValid}, 32'h1);
        checkOutput("mis_data", doneData, 32'h0);
        idleCycle();
        checkOutput("mis_align_after", {31'h0, bus.Align_err}, 32'h0);
        applyStimulus(1'b1, 1'b1, 8'h22, 32'h9999_9999);
        checkOutput("mis_st_we", weCycles, 0);
        checkOutput("mis_st_align", {31'h0, doneAlign}, 32'h1);
        checkOutput("mis_st_valid", {31'h0, doneValid}, 32'h0);
`else
        checkOutput("mis_stall", stallCycles, 5);
        checkOutput("mis_align", {31'h0, doneAlign}, 32'h0);
        checkOutput("mis_data", doneData, 32'hAABB_CCDD);
`endif
        idleCycle();

        // Reset in the cnt=2 cycle of a word store to 0x20.
        bus.MEM_enable_instr = 1'b1;
        bus.MEM_RW           = 1'b1;
        bus.MEM_size         = 1'b1;
        bus.MEM_ALU_out      = 8'h20;
        bus.MEM_PD           = 32'hA1B2_C3D4;
        @(negedge Clk);
        @(negedge Clk);
        @(negedge Clk);
        #1;
        checkOutput("mid_we_before", {31'h0, bus.Mem_WE}, 32'h1);
        checkOutput("mid_addr_before", {24'h0, bus.Mem_Addr}, 32'h22);
        #1 Reset = 1'b0;
        #1;
        checkOutput("mid_we_drop", {31'h0, bus.Mem_WE}, 32'h0);
        checkOutput("mid_stall_drop", {31'h0, bus.MEM_stall}, 32'h0);
        @(negedge Clk);
        Reset = 1'b1;
        bus.MEM_enable_instr = 1'b0;
        #1;
        checkOutput("mid_ram20", {24'h0, ram[8'h20]}, 32'hA1);
        checkOutput("mid_ram21", {24'h0, ram[8'h21]}, 32'hB2);
        checkOutput("mid_ram22", {24'h0, ram[8'h22]}, 32'h33);
        checkOutput("mid_ram23", {24'h0, ram[8'h23]}, 32'h44);
        checkOutput("mid_ldata", bus.Load_data, 32'h0);
        checkOutput("mid_lvalid", {31'h0, bus.Load_valid}, 32'h0);

        // FSM must be IDLE on release: a byte load takes the short path.
        applyStimulus(1'b0, 1'b0, 8'h05, 32'h0);
        checkOutput("post_gap", gapCycles, 0);
        checkOutput("post_stall", stallCycles, 2);
        checkOutput("post_data", doneData, 32'h0000_005A);
        idleCycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
